// File: rtl/regfile_mp.sv
// regfile_mp: multiported architectural register file.
// NUM_W retire writes (youngest port wins), NUM_R registered reads.
//
// Ports:
//   clk          rising-edge clock
//   rst          async active-low reset
//   wr_val       per-port write request
//   wr_addr      per-port destination register (packed)
//   wr_data      per-port write data (packed)
//   wr_drop      port lost arbitration this cycle (comb)
//   rd_val       per-port read request
//   rd_addr      per-port source register (packed)
//   rd_data      registered read data (packed)
//   rd_data_val  registered read-valid
module regfile_mp #(
  parameter int DATA_LEN = 32,
  parameter int RF_SIZE  = 32,
  parameter int NUM_W    = 4,
  parameter int NUM_R    = 8,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(RF_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_W-1:0]          wr_val,
  input  logic [NUM_W*AW-1:0]       wr_addr,
  input  logic [NUM_W*DATA_LEN-1:0] wr_data,
  output logic [NUM_W-1:0]          wr_drop,
  input  logic [NUM_R-1:0]          rd_val,
  input  logic [NUM_R*AW-1:0]       rd_addr,
  output logic [NUM_R*DATA_LEN-1:0] rd_data,
  output logic [NUM_R-1:0]          rd_data_val
);

  logic [DATA_LEN-1:0] regs [RF_SIZE];

  logic [AW-1:0]       waddr [NUM_W];
  logic [DATA_LEN-1:0] wdata [NUM_W];
  logic [AW-1:0]       raddr [NUM_R];
  logic [DATA_LEN-1:0] rnext [NUM_R];

  logic [NUM_W-1:0] eff;
  logic [NUM_W-1:0] win;

  always_comb begin
    for (int i = 0; i < NUM_W; i++) begin
      waddr[i] = wr_addr[i*AW +: AW];
      wdata[i] = wr_data[i*DATA_LEN +: DATA_LEN];
    end
    for (int r = 0; r < NUM_R; r++) begin
      raddr[r] = rd_addr[r*AW +: AW];
    end
  end

  // Register-0 writes are filtered before arbitration so they
  // neither win nor count as drops.
  always_comb begin
    eff = '0;
    win = '0;
    for (int i = 0; i < NUM_W; i++) begin
      eff[i] = wr_val[i] &
               !((ZERO_REG != 0) && (waddr[i] == '0));
    end
    for (int i = 0; i < NUM_W; i++) begin
      win[i] = eff[i];
      for (int j = i + 1; j < NUM_W; j++) begin
        if (eff[j] && (waddr[j] == waddr[i]))
          win[i] = 1'b0;
      end
    end
  end

  assign wr_drop = eff & ~win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < RF_SIZE; k++)
        regs[k] <= '0;
    end else begin
      for (int i = 0; i < NUM_W; i++) begin
        if (win[i])
          regs[waddr[i]] <= wdata[i];
      end
    end
  end

  // At most one winner per address, so the bypass
  // loop order does not matter.
  always_comb begin
    for (int r = 0; r < NUM_R; r++) begin
      rnext[r] = regs[raddr[r]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_W; i++) begin
          if (win[i] && (waddr[i] == raddr[r]))
            rnext[r] = wdata[i];
        end
      end
      if ((ZERO_REG != 0) && (raddr[r] == '0))
        rnext[r] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data     <= '0;
      rd_data_val <= '0;
    end else begin
      rd_data_val <= rd_val;
      for (int r = 0; r < NUM_R; r++) begin
        if (rd_val[r])
          rd_data[r*DATA_LEN +: DATA_LEN] <= rnext[r];
      end
    end
  end

endmodule
